// File: rtl/pll_seq_ctrl_if.sv
// Configuration handshake between a controller (master) and pll_seq_ctrl (slave).
//   cfg_req   : level request to apply cfg_odsel
//   cfg_odsel : new CLKOUT1 output-divider value
//   cfg_ack   : single-cycle acceptance pulse, decoded combinationally by the slave
interface pll_seq_ctrl_if;
  localparam int unsigned ODSEL_W = 7;

  logic               cfg_req;
  logic [ODSEL_W-1:0] cfg_odsel;
  logic               cfg_ack;

  modport master (output cfg_req, output cfg_odsel, input cfg_ack);
  modport slave  (input cfg_req, input cfg_odsel, output cfg_ack);
endinterface

// File: rtl/pll_seq_ctrl.sv
// PLL power-up / relock / reconfiguration sequencer.
// Holds the PLL in reset, waits for a stable lock, enables the downstream clock
// gate, and re-runs the sequence on lock loss or divider reconfiguration.
// Gives up into FAULT (PLL powered down) once the retry budget is spent.
//   clkin     : reference clock, all logic on its rising edge
//   rst_n     : asynchronous active-low reset
//   lock_i    : PLL LOCK, asynchronous to clkin
//   cfg       : request/ack handshake carrying the new ODSEL1 value
//   pll_reset : PLL RESET       pll_pwd : PLL PLLPWD
//   odsel     : PLL ODSEL1      enclk   : ENCLK0/ENCLK1
//   ready     : locked and clocks enabled
//   fault     : retry budget exhausted
//   state_o   : current state code
module pll_seq_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [6:0]  ODSEL_INIT   = 7'd9
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 lock_i,
  pll_seq_ctrl_if.slave        cfg,
  output logic                 pll_reset,
  output logic                 pll_pwd,
  output logic [6:0]           odsel,
  output logic                 enclk,
  output logic                 ready,
  output logic                 fault,
  output logic [2:0]           state_o
);

  localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_GATE      = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  typedef struct packed {
    logic pll_reset;
    logic pll_pwd;
    logic enclk;
    logic ready;
    logic fault;
  } ctrl_out_t;

  state_t             state;
  ctrl_out_t          outs;
  logic               sync_meta;
  logic               lock_s;
  logic [RST_W-1:0]   rst_cnt;
  logic [STAB_W-1:0]  stab_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               gate_cnt;
  logic [RETRY_W-1:0] retry;

  logic rst_done;
  logic stable_hit;
  logic tmo_hit;
  logic retry_ok;

  // Output levels registered alongside the state they belong to.
  function automatic ctrl_out_t decode_outs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_RST:   o.pll_reset = 1'b1;
      ST_RUN:   begin
        o.enclk = 1'b1;
        o.ready = 1'b1;
      end
      ST_FAULT: begin
        o.pll_reset = 1'b1;
        o.pll_pwd   = 1'b1;
        o.fault     = 1'b1;
      end
      default:  o = '0;
    endcase
    return o;
  endfunction

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync_meta <= lock_i;
      lock_s    <= sync_meta;
    end
  end

  assign rst_done   = (rst_cnt == RST_W'(RST_CYCLES - 1));
  // Stable lock fires on the LOCK_STABLE-th consecutive synchronized lock cycle.
  assign stable_hit = lock_s && (stab_cnt == STAB_W'(LOCK_STABLE - 1));
  assign tmo_hit    = (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
  assign retry_ok   = (retry < RETRY_W'(MAX_RETRY));

  // Requests are only honoured in RUN and FAULT; elsewhere they wait unacknowledged.
  assign cfg.cfg_ack = cfg.cfg_req && ((state == ST_RUN) || (state == ST_FAULT));

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      outs     <= decode_outs(ST_RST);
      odsel    <= ODSEL_INIT;
      rst_cnt  <= '0;
      stab_cnt <= '0;
      tmo_cnt  <= '0;
      gate_cnt <= 1'b0;
      retry    <= '0;
    end else begin
      case (state)
        ST_RST: begin
          stab_cnt <= '0;
          tmo_cnt  <= '0;
          if (rst_done) begin
            rst_cnt <= '0;
            state   <= ST_WAIT_LOCK;
            outs    <= decode_outs(ST_WAIT_LOCK);
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          stab_cnt <= lock_s ? stab_cnt + STAB_W'(1) : '0;
          tmo_cnt  <= tmo_cnt + TMO_W'(1);
          // Stable lock takes priority over a coincident timeout.
          if (stable_hit) begin
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            retry    <= '0;
            state    <= ST_RUN;
            outs     <= decode_outs(ST_RUN);
          end else if (tmo_hit) begin
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            if (retry_ok) begin
              retry <= retry + RETRY_W'(1);
              state <= ST_RST;
              outs  <= decode_outs(ST_RST);
            end else begin
              state <= ST_FAULT;
              outs  <= decode_outs(ST_FAULT);
            end
          end
        end

        ST_RUN: begin
          // Reconfiguration wins over a coincident lock loss and restarts the budget.
          if (cfg.cfg_req) begin
            odsel <= cfg.cfg_odsel;
            retry <= '0;
            state <= ST_GATE;
            outs  <= decode_outs(ST_GATE);
          end else if (!lock_s) begin
            if (retry_ok) begin
              retry <= retry + RETRY_W'(1);
              state <= ST_GATE;
              outs  <= decode_outs(ST_GATE);
            end else begin
              state <= ST_FAULT;
              outs  <= decode_outs(ST_FAULT);
            end
          end
        end

        ST_GATE: begin
          // Two cycles with clocks gated before the PLL is put back into reset.
          if (gate_cnt) begin
            gate_cnt <= 1'b0;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= ST_RST;
            outs     <= decode_outs(ST_RST);
          end else begin
            gate_cnt <= 1'b1;
          end
        end

        ST_FAULT: begin
          if (cfg.cfg_req) begin
            odsel    <= cfg.cfg_odsel;
            retry    <= '0;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= ST_RST;
            outs     <= decode_outs(ST_RST);
          end
        end

        default: begin
          rst_cnt  <= '0;
          stab_cnt <= '0;
          tmo_cnt  <= '0;
          gate_cnt <= 1'b0;
          state    <= ST_RST;
          outs     <= decode_outs(ST_RST);
        end
      endcase
    end
  end

  assign pll_reset = outs.pll_reset;
  assign pll_pwd   = outs.pll_pwd;
  assign enclk     = outs.enclk;
  assign ready     = outs.ready;
  assign fault     = outs.fault;
  assign state_o   = 3'(state);

endmodule
